mse_min_ref: RTL and testbench

Best-match selector that sits directly downstream of the MSE register stage. It consumes the stream of per-library-vector mean-square-error results (value plus library reference index) for one pixel. It tracks the running minimum and, once the programmed number of results has arrived, emits the winning reference index and its MSE as a single-cycle result. This result is the final spectral-identification decision for the pixel.

---
 rtl/mse_min_ref_if.sv | 31 +++
 rtl/mse_min_ref.sv | 92 +++++++++
 tb/tb_mse_min_ref.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mse_min_ref_if.sv
// Handshake/result bundle between the MSE register stage, the best-match
// selector and whatever consumes the per-pixel decision.
interface mse_min_ref_if #(
  parameter int WORD_WIDTH       = 32,
  parameter int HSI_LIBRARY_SIZE = 256
);
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE);

  // mse_valid qualifies mse_value/mse_ref for exactly the cycle it is high.
  // There is no ready: every valid seen in SEARCH is consumed. min_valid is
  // a one-cycle pulse that qualifies min_value/min_ref.
  logic                             start;
  logic [HSI_LIBRARY_SIZE_ADDR:0]   vctr_count;
  logic [WORD_WIDTH-1:0]            mse_value;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_ref;
  logic                             mse_valid;
  logic                             busy;
  logic [WORD_WIDTH-1:0]            min_value;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref;
  logic                             min_valid;

  modport master (
    output start, vctr_count, mse_value, mse_ref, mse_valid,
    input  busy, min_value, min_ref, min_valid
  );

  modport slave (
    input  start, vctr_count, mse_value, mse_ref, mse_valid,
    output busy, min_value, min_ref, min_valid
  );
endinterface

// File: rtl/mse_min_ref.sv
// Running-minimum selector over one pixel's stream of MSE results; emits the
// winning library index and its MSE as a single-cycle result pulse.
module mse_min_ref #(
  parameter int WORD_WIDTH       = 32,
  parameter int HSI_LIBRARY_SIZE = 256
) (
  input  logic               clk,
  input  logic               rst,
  mse_min_ref_if.slave       bus,
  output logic [1:0]         fsm_state
);
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE);
  localparam int CW = HSI_LIBRARY_SIZE_ADDR + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                           state;
  logic [CW-1:0]                    target_q;
  logic [CW-1:0]                    cnt_q;
  logic [CW-1:0]                    cnt_next;
  logic                             busy_q;
  logic                             min_valid_q;
  logic [WORD_WIDTH-1:0]            min_value_q;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref_q;
  logic                             start_ok;

  assign cnt_next = cnt_q + CNT_ONE;
  assign start_ok = bus.start && (bus.vctr_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      min_valid_q <= 1'b0;
      min_value_q <= '0;
      min_ref_q   <= '0;
    end else begin
      min_valid_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE behaves like IDLE for new starts; its pulse is already out.
          if (start_ok) begin
            target_q <= bus.vctr_count;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state    <= SEARCH;
          end else begin
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        SEARCH: begin
          if (bus.start) begin
            // Abort: any simultaneous sample is dropped, no result pulse.
            target_q <= bus.vctr_count;
            cnt_q    <= '0;
            busy_q   <= start_ok;
            state    <= start_ok ? SEARCH : IDLE;
          end else if (bus.mse_valid) begin
            if ((cnt_q == '0) || (bus.mse_value < min_value_q)) begin
              min_value_q <= bus.mse_value;
              min_ref_q   <= bus.mse_ref;
            end
            cnt_q <= cnt_next;
            if (cnt_next == target_q) begin
              busy_q      <= 1'b0;
              min_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.min_valid = min_valid_q;
  assign bus.min_value = min_value_q;
  assign bus.min_ref   = min_ref_q;
  assign fsm_state     = state;
endmodule

// File: tb/tb_mse_min_ref.sv
// Bench for mse_min_ref: directed scenarios plus random traffic, checked
// against a sample-list reference model through an expected-result queue.
module tb_mse_min_ref;
  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;

  mse_min_ref_if #(.WORD_WIDTH(32), .HSI_LIBRARY_SIZE(256)) bus ();

  mse_min_ref #(.WORD_WIDTH(32), .HSI_LIBRARY_SIZE(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  logic [39:0] exp_q[$];
  logic [39:0] last_res;

  // reference model: samples of the open search, matched against its target
  bit          m_search;
  int          m_target;
  logic [31:0] m_vals[$];
  logic [7:0]  m_refs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit s, input int cnt, input bit v,
                            input logic [31:0] val, input logic [7:0] r);
    int best;
    if (m_search) begin
      if (s) begin
        m_vals.delete(); m_refs.delete();
        m_target = cnt;
        m_search = (cnt != 0);
      end else if (v) begin
        m_vals.push_back(val);
        m_refs.push_back(r);
        if (m_vals.size() == m_target) begin
          best = 0;
          for (int i = 1; i < m_vals.size(); i++)
            if (m_vals[i] < m_vals[best]) best = i;
          last_res = {m_refs[best], m_vals[best]};
          exp_q.push_back(last_res);
          m_search = 1'b0;
        end
      end
    end else if (s && cnt != 0) begin
      m_vals.delete(); m_refs.delete();
      m_target = cnt;
      m_search = 1'b1;
    end
  endtask

  // driver: one clock cycle of inputs, then the busy check after the edge
  task automatic drive(input bit s, input int cnt, input bit v,
                       input logic [31:0] val, input logic [7:0] r);
    logic [8:0] c9;
    c9 = cnt[8:0];
    bus.start = s; bus.vctr_count = c9;
    bus.mse_valid = v; bus.mse_value = val; bus.mse_ref = r;
    model_step(s, cnt, v, val, r);
    @(posedge clk); #1;
    check("busy", {63'd0, bus.busy}, {63'd0, m_search});
    bus.start = 1'b0; bus.mse_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'd0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.mse_valid = 1'b0;
    m_search = 1'b0; m_vals.delete(); m_refs.delete();
    last_res = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_min_valid", {63'd0, bus.min_valid}, 64'd0);
    check("rst_min_value", {32'd0, bus.min_value}, 64'd0);
    check("rst_min_ref", {56'd0, bus.min_ref}, 64'd0);
    check("rst_state", {62'd0, fsm_state}, 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.min_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_min_valid", {24'd0, bus.min_ref, bus.min_value}, 64'd0);
      end else begin
        check("result", {24'd0, bus.min_ref, bus.min_value}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int pulses_before;

  initial begin
    bus.start = 0; bus.vctr_count = '0; bus.mse_valid = 0;
    bus.mse_value = '0; bus.mse_ref = '0;
    m_search = 0; m_target = 0; last_res = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // basic search
    drive(1, 4, 0, 0, 0);
    drive(0, 0, 1, 32'd50, 8'd0);
    drive(0, 0, 1, 32'd20, 8'd1);
    drive(0, 0, 1, 32'd70, 8'd2);
    drive(0, 0, 1, 32'd30, 8'd3);
    idle(3);
    check("hold_value", {32'd0, bus.min_value}, 64'd20);

    // ties at all-ones keep the first index
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 32'hFFFF_FFFF, 8'd5);
    drive(0, 0, 1, 32'hFFFF_FFFF, 8'd6);
    drive(0, 0, 1, 32'hFFFF_FFFF, 8'd7);
    idle(2);

    // full library with random gaps, minimum at the last index
    drive(1, 256, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      while ($urandom_range(0, 3) == 0) idle(1);
      drive(0, 0, 1, (i == 255) ? 32'd3 : $urandom_range(4, 32'h7FFF_FFFF), i[7:0]);
    end
    idle(2);

    // abort and restart with a dropped simultaneous sample
    drive(1, 4, 0, 0, 0);
    drive(0, 0, 1, 32'd40, 8'd0);
    drive(0, 0, 1, 32'd41, 8'd1);
    drive(1, 2, 1, 32'd1, 8'd9);
    drive(0, 0, 1, 32'd9, 8'd0);
    drive(0, 0, 1, 32'd8, 8'd1);
    idle(2);

    // ignored inputs in IDLE
    pulses_before = n_pulses;
    drive(0, 0, 1, 32'd0, 8'd4);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 32'd0, 8'd4);
    idle(2);
    check("ignored_no_pulse", n_pulses, pulses_before);
    check("ignored_hold", {24'd0, bus.min_ref, bus.min_value}, {24'd0, last_res});

    // reset mid-search
    drive(1, 4, 0, 0, 0);
    drive(0, 0, 1, 32'd5, 8'd0);
    drive(0, 0, 1, 32'd6, 8'd1);
    do_reset();
    pulses_before = n_pulses;
    drive(0, 0, 1, 32'd2, 8'd2);
    drive(0, 0, 1, 32'd1, 8'd3);
    idle(2);
    check("reset_no_pulse", n_pulses, pulses_before);

    // random traffic: starts, aborts, gaps, ties
    for (int i = 0; i < 600; i++) begin
      bit s;
      s = m_search ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      drive(s, $urandom_range(0, 12), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15), $urandom_range(0, 255));
    end
    idle(3);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
